// File: rtl/serial_paralelo.sv
// serial_paralelo
//   Serial-to-parallel receiver for the PCI physical-layer datapath. It takes the
//   MSB-first bit stream from paralelo_serial and finds byte alignment on the COM
//   character. The link becomes active after ACTIVE_COUNT consecutive aligned COM
//   bytes. From then on, every non-COM byte is delivered with a valid flag.
//
// Parameters
//   COM_CHAR      idle/alignment character (default 8'hBC)
//   ACTIVE_COUNT  consecutive aligned COMs needed to go active (1..15)
//
// Ports
//   clk_32f      in   bit clock; all state changes on the rising edge
//   reset        in   synchronous, active-low; clears all state
//   data_in      in   serial bit, MSB of each byte first
//   data_out     out  [7:0] last recovered non-COM byte, held between boundaries
//   valid_out    out  data_out holds a valid byte for the current byte period
//   active       out  link aligned and active; sticky until reset
//   byte_strobe  out  one-cycle pulse at each byte boundary once aligned
module serial_paralelo #(
  parameter logic [7:0]  COM_CHAR     = 8'hBC,
  parameter int unsigned ACTIVE_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  typedef enum logic [1:0] {
    ST_UNALIGNED = 2'd0,
    ST_ALIGNING  = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  localparam logic [3:0] ACT_CNT = 4'(ACTIVE_COUNT);

  state_t     state, state_nxt;
  logic [7:0] shift_reg;
  logic [7:0] win;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [3:0] com_inc;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       active_nxt;
  logic       strobe_nxt;
  logic       is_com;
  logic       boundary;

  // The window includes the bit being sampled now. Outputs therefore update on
  // the same edge that samples a byte's last bit, with no extra pipeline stage.
  assign win      = {shift_reg[6:0], data_in};
  assign is_com   = (win == COM_CHAR);
  assign boundary = (bit_cnt == 3'd7);
  assign com_inc  = com_cnt + 4'd1;

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state       <= ST_UNALIGNED;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      com_cnt     <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= win;
      bit_cnt     <= bit_cnt_nxt;
      com_cnt     <= com_cnt_nxt;
      data_out    <= data_nxt;
      valid_out   <= valid_nxt;
      active      <= active_nxt;
      byte_strobe <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_out;
    valid_nxt   = valid_out;
    active_nxt  = active;
    strobe_nxt  = 1'b0;

    case (state)
      ST_UNALIGNED: begin
        // Search every bit position. A match defines this edge as a byte
        // boundary, so the bit counter restarts from zero.
        bit_cnt_nxt = '0;
        if (is_com) begin
          com_cnt_nxt = 4'd1;
          strobe_nxt  = 1'b1;
          if (ACT_CNT == 4'd1) begin
            active_nxt = 1'b1;
            state_nxt  = ST_ACTIVE;
          end else begin
            state_nxt = ST_ALIGNING;
          end
        end
      end

      ST_ALIGNING: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        valid_nxt   = 1'b0;
        if (boundary) begin
          strobe_nxt = 1'b1;
          if (is_com) begin
            com_cnt_nxt = com_inc;
            if (com_inc == ACT_CNT) begin
              active_nxt = 1'b1;
              state_nxt  = ST_ACTIVE;
            end
          end else begin
            com_cnt_nxt = '0;
            state_nxt   = ST_UNALIGNED;
          end
        end
      end

      ST_ACTIVE: begin
        // Once active, the link stays active until reset. Loss of alignment
        // is not detected here.
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_nxt = 1'b1;
          if (is_com) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt  = win;
            valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_UNALIGNED;
      end
    endcase
  end

endmodule
